z_mask_capture: RTL and testbench



---
 rtl/zmask_pkg.sv | 26 ++
 rtl/zmask_slot_ctr.sv | 43 ++++
 rtl/z_mask_capture.sv | 157 +++++++++++++++
 tb/tb_z_mask_capture.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/zmask_pkg.sv
// ============================================================================
// Module      : zmask_pkg
// Description : Shared types, default sizes and slot-wrap helper for
//               z_mask_capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package zmask_pkg;

    localparam int c_SLOTS_DEFAULT = 17;
    localparam int c_CW_DEFAULT    = 5;

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        CAPTURE = 1'b1
    } zmask_state_e;

    // Wraps to 0 after the last slot, so the counter never visits unused codes.
    function automatic int next_slot(input int slot, input int slots);
        return (slot >= slots - 1) ? 0 : slot + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/zmask_slot_ctr.sv
// ============================================================================
// Module      : zmask_slot_ctr
// Description : Frame slot counter with enable, clear, load-1 and terminal
//               count (slot == SLOTS-1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module zmask_slot_ctr
    import zmask_pkg::*;
#(
    parameter int SLOTS = c_SLOTS_DEFAULT,
    parameter int CW    = c_CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_clr,
    input  logic          i_ld1,
    output logic [CW-1:0] o_slot,
    output logic          o_tc
);

    logic [CW-1:0] r_slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= '0;
        end else if (i_clr) begin
            r_slot <= '0;
        end else if (i_ld1) begin
            r_slot <= CW'(1);
        end else if (i_en) begin
            r_slot <= CW'(next_slot(int'(r_slot), SLOTS));
        end
    end

    assign o_slot = r_slot;
    assign o_tc   = (r_slot == CW'(SLOTS - 1));

endmodule

`default_nettype wire

// File: rtl/z_mask_capture.sv
// ============================================================================
// Module      : z_mask_capture
// Description : Rebuilds the slot mask from the serial match stream Z and
//               publishes each complete frame; flags SYNC misalignment.
//               Optional macro Z_MASK_CHG_EN builds the MASK_CHG logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module z_mask_capture
    import zmask_pkg::*;
#(
    parameter int SLOTS = c_SLOTS_DEFAULT,
    parameter int CW    = c_CW_DEFAULT
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             P_0,
    input  logic             Z,
    input  logic             SYNC,
    output logic [SLOTS-1:0] MASK,
    output logic             MASK_VALID,
    output logic             MASK_CHG,
    output logic             SYNC_ERR
);

    localparam logic [0:0] c_ST_HUNT    = HUNT;
    localparam logic [0:0] c_ST_CAPTURE = CAPTURE;

    logic [0:0]       r_state;
    logic [SLOTS-1:0] r_shadow;
    logic [SLOTS-1:0] r_mask;
    logic             r_valid;
    logic             r_err;

    logic [0:0]       w_state_next;
    logic [SLOTS-1:0] w_shadow_next;
    logic [CW-1:0]    w_slot;
    logic             w_tc;
    logic             w_en;
    logic             w_clr;
    logic             w_ld1;
    logic             w_store;
    logic             w_store0;
    logic             w_publish;
    logic             w_err;

    zmask_slot_ctr #(
        .SLOTS (SLOTS),
        .CW    (CW)
    ) u_slot_ctr (
        .clk    (CK),
        .rst    (RST),
        .i_en   (w_en),
        .i_clr  (w_clr),
        .i_ld1  (w_ld1),
        .o_slot (w_slot),
        .o_tc   (w_tc)
    );

    always_comb begin
        w_state_next = r_state;
        w_en         = 1'b0;
        w_clr        = 1'b0;
        w_ld1        = 1'b0;
        w_store      = 1'b0;
        w_store0     = 1'b0;
        w_publish    = 1'b0;
        w_err        = 1'b0;
        if (P_0) begin
            if (r_state == c_ST_HUNT) begin
                if (SYNC) begin
                    w_store0     = 1'b1;
                    w_ld1        = 1'b1;
                    w_state_next = c_ST_CAPTURE;
                end
            end else if (w_slot == '0) begin
                if (SYNC) begin
                    w_store0 = 1'b1;
                    w_ld1    = 1'b1;
                end else begin
                    w_err        = 1'b1;
                    w_clr        = 1'b1;
                    w_state_next = c_ST_HUNT;
                end
            end else if (SYNC) begin
                // Early SYNC: restart the frame in place rather than hunting.
                w_err    = 1'b1;
                w_store0 = 1'b1;
                w_ld1    = 1'b1;
            end else begin
                w_store   = 1'b1;
                w_en      = 1'b1;
                w_publish = w_tc;
            end
        end
    end

    always_comb begin
        w_shadow_next = r_shadow;
        for (int k = 0; k < SLOTS; k++) begin
            if ((w_store && (w_slot == CW'(k))) || (w_store0 && (k == 0))) begin
                w_shadow_next[k] = Z;
            end
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            r_state  <= c_ST_HUNT;
            r_shadow <= '0;
            r_mask   <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_shadow <= w_shadow_next;
            r_valid  <= w_publish;
            r_err    <= w_err;
            if (w_publish) begin
                r_mask <= w_shadow_next;
            end
        end
    end

`ifdef Z_MASK_CHG_EN
    logic [SLOTS-1:0] r_prev_mask;
    logic             r_first;
    logic             r_chg;

    // The first frame after reset always reports a change, even if it is 0.
    always_ff @(posedge CK) begin
        if (RST) begin
            r_prev_mask <= '0;
            r_first     <= 1'b1;
            r_chg       <= 1'b0;
        end else if (w_publish) begin
            r_chg       <= r_first || (w_shadow_next != r_prev_mask);
            r_prev_mask <= w_shadow_next;
            r_first     <= 1'b0;
        end else begin
            r_chg <= 1'b0;
        end
    end

    assign MASK_CHG = r_chg;
`else
    assign MASK_CHG = 1'b0;
`endif

    assign MASK       = r_mask;
    assign MASK_VALID = r_valid;
    assign SYNC_ERR   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_z_mask_capture.sv
// ============================================================================
// Module      : tb_z_mask_capture
// Description : Self-checking bench for z_mask_capture (SLOTS=17) with a
//               queue of expected published frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_z_mask_capture;

    localparam int SLOTS = 17;

    logic              CK = 1'b0;
    logic              RST;
    logic              P_0;
    logic              Z;
    logic              SYNC;
    logic [SLOTS-1:0]  MASK;
    logic              MASK_VALID;
    logic              MASK_CHG;
    logic              SYNC_ERR;

    int                n_cmp = 0;
    int                n_err = 0;

    logic [SLOTS-1:0]  q_mask[$];
    logic              q_chg[$];
    logic [SLOTS-1:0]  m_prev;
    logic [SLOTS-1:0]  m_last;
    logic              m_first;

    always #5 CK = ~CK;

    z_mask_capture #(
        .SLOTS (SLOTS),
        .CW    (5)
    ) dut (
        .CK         (CK),
        .RST        (RST),
        .P_0        (P_0),
        .Z          (Z),
        .SYNC       (SYNC),
        .MASK       (MASK),
        .MASK_VALID (MASK_VALID),
        .MASK_CHG   (MASK_CHG),
        .SYNC_ERR   (SYNC_ERR)
    );

    task automatic step(input logic p, input logic z, input logic s);
        P_0  = p;
        Z    = z;
        SYNC = s;
        @(posedge CK);
        #1;
    endtask

    // Drives one frame (slot 0 first) and checks every cycle of it.
    task automatic send_frame(input logic [SLOTS-1:0] m, input bit gaps,
                              input bit resync, input string tag);
        logic             c;
        logic [SLOTS-1:0] em;
        logic             ec;
`ifdef Z_MASK_CHG_EN
        c = m_first || (m != m_prev);
`else
        c = 1'b0;
`endif
        q_mask.push_back(m);
        q_chg.push_back(c);
        m_prev  = m;
        m_first = 1'b0;
        for (int k = 0; k < SLOTS; k++) begin
            step(1'b1, m[k], k == 0);
            if (k == 0) begin
                n_cmp++;
                if (SYNC_ERR !== resync) begin
                    n_err++;
                    $display("FAIL %s sync_err_slot0: got %b expected %b", tag, SYNC_ERR, resync);
                end
            end else if (k == 1) begin
                n_cmp++;
                if (SYNC_ERR !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s sync_err_slot1: got %b expected 0", tag, SYNC_ERR);
                end
            end
            if (k < SLOTS - 1) begin
                n_cmp++;
                if (MASK_VALID !== 1'b0 || MASK !== m_last) begin
                    n_err++;
                    $display("FAIL %s hold_slot%0d: got valid=%b mask=%h expected valid=0 mask=%h",
                             tag, k, MASK_VALID, MASK, m_last);
                end
            end else begin
                n_cmp++;
                if (MASK_VALID !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s valid: got %b expected 1", tag, MASK_VALID);
                end
                if (q_mask.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL %s scoreboard_empty: got 0 entries expected 1", tag);
                end else begin
                    em = q_mask.pop_front();
                    ec = q_chg.pop_front();
                    n_cmp++;
                    if (MASK !== em) begin
                        n_err++;
                        $display("FAIL %s mask: got %h expected %h", tag, MASK, em);
                    end
                    n_cmp++;
                    if (MASK_CHG !== ec) begin
                        n_err++;
                        $display("FAIL %s mask_chg: got %b expected %b", tag, MASK_CHG, ec);
                    end
                    m_last = em;
                end
            end
            if (gaps) begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                n_cmp++;
                if (MASK_VALID !== 1'b0 || SYNC_ERR !== 1'b0 || MASK_CHG !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s gap%0d: got valid=%b err=%b chg=%b expected 0 0 0",
                             tag, k, MASK_VALID, SYNC_ERR, MASK_CHG);
                end
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (MASK !== '0 || MASK_VALID !== 1'b0 || MASK_CHG !== 1'b0 || SYNC_ERR !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got mask=%h v=%b c=%b e=%b expected all 0",
                     MASK, MASK_VALID, MASK_CHG, SYNC_ERR);
        end
        RST     = 1'b0;
        m_first = 1'b1;
        m_prev  = '0;
        m_last  = '0;
        q_mask.delete();
        q_chg.delete();
    endtask

    task automatic test_single();
        send_frame(17'h1_0005, 1'b0, 1'b0, "single");
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (MASK_VALID !== 1'b0 || MASK !== 17'h1_0005) begin
            n_err++;
            $display("FAIL single_one_cycle: got valid=%b mask=%h expected 0 10005", MASK_VALID, MASK);
        end
    endtask

    task automatic test_gaps();
        send_frame(17'h1_0005, 1'b1, 1'b0, "gaps");
    endtask

    task automatic test_back_to_back();
        send_frame(17'h0_00FF, 1'b0, 1'b0, "b2b_first");
        send_frame(17'h0_00FF, 1'b0, 1'b0, "b2b_second");
    endtask

    task automatic test_sync_misplaced();
        logic [SLOTS-1:0] junk;
        junk = 17'h1_2345;
        for (int k = 0; k < 9; k++) begin
            step(1'b1, junk[k], k == 0);
            n_cmp++;
            if (MASK_VALID !== 1'b0 || SYNC_ERR !== 1'b0) begin
                n_err++;
                $display("FAIL misplaced_prefix%0d: got valid=%b err=%b expected 0 0", k, MASK_VALID, SYNC_ERR);
            end
        end
        send_frame(17'h0_ABCD, 1'b0, 1'b1, "misplaced");
    endtask

    task automatic test_sync_missing();
        step(1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (SYNC_ERR !== 1'b1 || MASK_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL missing_err: got err=%b valid=%b expected 1 0", SYNC_ERR, MASK_VALID);
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            n_cmp++;
            if (SYNC_ERR !== 1'b0 || MASK_VALID !== 1'b0) begin
                n_err++;
                $display("FAIL missing_hunt%0d: got err=%b valid=%b expected 0 0", k, SYNC_ERR, MASK_VALID);
            end
        end
        send_frame(17'h1_F0F0, 1'b0, 1'b0, "missing_recover");
    endtask

    task automatic test_reset_midframe();
        logic [SLOTS-1:0] part;
        part = 17'h1_5555;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, part[k], k == 0);
        end
        RST = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (MASK !== '0 || MASK_VALID !== 1'b0 || MASK_CHG !== 1'b0 || SYNC_ERR !== 1'b0) begin
            n_err++;
            $display("FAIL midframe_reset: got mask=%h v=%b c=%b e=%b expected all 0",
                     MASK, MASK_VALID, MASK_CHG, SYNC_ERR);
        end
        RST     = 1'b0;
        m_first = 1'b1;
        m_prev  = '0;
        m_last  = '0;
        send_frame(17'h0_0000, 1'b0, 1'b0, "after_reset_zero");
        send_frame(17'h0_00FF, 1'b0, 1'b0, "after_reset_ff");
    endtask

    initial begin
        RST  = 1'b1;
        P_0  = 1'b0;
        Z    = 1'b0;
        SYNC = 1'b0;
        test_reset();
        test_single();
        test_gaps();
        test_back_to_back();
        test_sync_misplaced();
        test_sync_missing();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
